// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge between the CPU data port and data memory.
// Decodes RAM vs. local I/O registers (LEDs, switches, hex scanner, compare timer).
module io_bridge #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned SW_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            dm_we,
    input  logic [31:0]     dm_rdata,
    input  logic [SW_W-1:0] sw,
    output logic [15:0]     led,
    output logic [7:0]      seg_an,
    output logic [3:0]      seg_hex,
    output logic            timer_irq
);

    typedef enum logic [5:0] {
        REG_LED  = 6'h00,
        REG_SW   = 6'h01,
        REG_SEG  = 6'h02,
        REG_CNT  = 6'h03,
        REG_CMP  = 6'h04,
        REG_CTRL = 6'h05
    } io_reg_e;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic            ram_sel, io_sel, io_we;
    logic [5:0]      word_off;
    logic            wr_led, wr_seg, wr_cnt, wr_cmp, wr_ctrl;
    logic            unused_addr_bits;

    logic [15:0]     led_q;
    logic [31:0]     seg_q;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     cmp_q;
    logic            en_q, auto_q;
    logic            st_q, st_d;
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    logic [15:0]     div_q, div_d;
    logic [2:0]      idx_q, idx_d;
    logic            match;

    assign ram_sel  = (addr[31:9] == 23'd0);
    assign io_sel   = (addr[31:8] == 24'h00007F);
    assign word_off = addr[7:2];
    assign io_we    = mem_we & io_sel;
    assign unused_addr_bits = ^addr[1:0];

    assign wr_led  = io_we && (word_off == REG_LED);
    assign wr_seg  = io_we && (word_off == REG_SEG);
    assign wr_cnt  = io_we && (word_off == REG_CNT);
    assign wr_cmp  = io_we && (word_off == REG_CMP);
    assign wr_ctrl = io_we && (word_off == REG_CTRL);

    assign dm_we = mem_we & ram_sel;

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = dm_rdata;
        end else if (io_sel) begin
            case (word_off)
                REG_LED:  rdata = {16'h0000, led_q};
                REG_SW:   rdata = 32'(sw_sync_q);
                REG_SEG:  rdata = seg_q;
                REG_CNT:  rdata = cnt_q;
                REG_CMP:  rdata = cmp_q;
                REG_CTRL: rdata = {29'd0, st_q, auto_q, en_q};
                default:  rdata = '0;
            endcase
        end
    end

    // A CNT write pre-empts both counting and the match that would set ST;
    // a match on the same edge as a W1C clear leaves ST set.
    always_comb begin
        match = en_q && (cnt_q == cmp_q);
        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = wdata;
        end else if (match && auto_q) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + 32'd1;
        end
        st_d = st_q;
        if (wr_ctrl && wdata[2]) begin
            st_d = 1'b0;
        end
        if (match && !wr_cnt) begin
            st_d = 1'b1;
        end
    end

    always_comb begin
        div_d = div_q + 16'd1;
        idx_d = idx_q;
        if (div_q >= DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            seg_q     <= '0;
            cnt_q     <= '0;
            cmp_q     <= '1;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            st_q      <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            div_q     <= '0;
            idx_q     <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            if (wr_led) begin
                led_q <= wdata[15:0];
            end
            if (wr_seg) begin
                seg_q <= wdata;
            end
            if (wr_cmp) begin
                cmp_q <= wdata;
            end
            if (wr_ctrl) begin
                en_q   <= wdata[0];
                auto_q <= wdata[1];
            end
            cnt_q <= cnt_d;
            st_q  <= st_d;
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    assign led       = led_q;
    assign timer_irq = st_q;
    assign seg_an    = ~(8'h01 << idx_q);
    assign seg_hex   = seg_q[{idx_q, 2'b00} +: 4];

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped I/O bridge directly downstream of the single-cycle CPU data port. Sits between the CPU data port and the data memory.
- Decodes the CPU byte address:
  - RAM-region accesses go to data memory.
  - I/O-region accesses hit local registers: LEDs, switches, an 8-digit hex display scanner and a compare timer with interrupt.
- Read data back to the CPU is combinational, preserving single-cycle load timing.

Parameters:
- SCAN_DIV, 16, clk cycles per display digit slot (range 2..65535; small for simulation, large on board).
- SW_W, 16, switch input width.

Ports:
- clk  in  1  CPU clock
- rst  in  1  asynchronous active-high reset
- mem_we  in  1  CPU store strobe (MemWrite)
- addr  in  32  CPU byte address (aluout)
- wdata  in  32  CPU store data
- rdata  out  32  load data to CPU readdata
- dm_we  out  1  data memory write enable
- dm_rdata  in  32  data memory read data
- sw  in  SW_W  raw switch inputs (asynchronous)
- led  out  16  LED register
- seg_an  out  8  digit enables, one-hot, active-low
- seg_hex  out  4  hex nibble for the enabled digit
- timer_irq  out  1  timer interrupt, level

Behaviour:
- Reset is asynchronous. While rst=1 and on its release, the following hold:
  - led=0, SEG=0, CNT=0, CMP=0xFFFFFFFF, CTRL=0, irq status=0.
  - Switch synchronizer flops are 0.
  - Scan divider is 0 and digit index is 0, so seg_an=8'hFE and seg_hex=0.
- Address decode uses addr[1:0] ignored (word access only).
  - RAM region: addr[31:9]==0. In this region dm_we=mem_we and rdata=dm_rdata.
  - IO region: addr[31:8]==24'h00007F. In this region dm_we=0.
  - Any other address: dm_we=0, rdata=0, writes dropped.
- IO map (offset = addr[7:0]):
  - 0x00 LED: RW, bits[15:0]; reads return upper bits 0.
  - 0x04 SW: RO, zero-extended synchronized switches; writes ignored.
  - 0x08 SEG: RW, 32-bit; digit i displays SEG[4i+3:4i].
  - 0x0C CNT: RW; a write loads the counter.
  - 0x10 CMP: RW.
  - 0x14 CTRL:
    - bit0 EN: RW.
    - bit1 AUTO (auto-reload): RW.
    - bit2 ST (irq status): read returns status; writing 1 clears it (W1C).
    - Other bits read 0.
  - Unmapped IO offsets read 0; writes are ignored.
- Register writes take effect on the rising clk edge where mem_we=1. A read in the same cycle returns the old value.
- Switches pass through a 2-flop synchronizer. A pin change is visible on an SW read after 2 rising edges.
- Timer, evaluated every edge:
  - If a CNT write occurs, CNT←wdata. This has priority over counting.
  - Else if EN and CNT==CMP:
    - ST←1.
    - CNT←0 if AUTO, otherwise CNT←CNT+1 (wraps modulo 2^32).
  - Else if EN: CNT←CNT+1.
  - timer_irq=ST (registered).
  - Simultaneous match and W1C clear on the same edge: set wins, so ST stays 1.
  - Clearing EN freezes CNT. A match on a frozen counter does not set ST.
- Display scanner:
  - Divider counts 0..SCAN_DIV-1. On wrap, the digit index advances (7→0 wraps).
  - seg_an = ~(1<<index).
  - seg_hex = SEG nibble of the current index, combinational from registers (a SEG write shows on the next cycle).
- Reset mid-operation clears all state immediately; no partial writes survive.

Test Plan:
- Reset then RAM access:
  - Stimulus: assert rst; then store 0x12345678 to addr 0x0000_0010, followed by a load.
  - Required: dm_we=1 only in the store cycle; load rdata=dm_rdata.
  - Required: a store to 0x0000_7F00 gives dm_we=0.
- LED and SW:
  - Stimulus: store 0xFFFF_ABCD to 0x7F00.
  - Required: led=0xABCD and readback is 0x0000ABCD.
  - Stimulus: set sw=0x00F0.
  - Required: a load of 0x7F04 returns 0x000000F0 from the 2nd edge onward, and 0 before that.
- Timer one-shot:
  - Stimulus: CMP=5, CNT=0, CTRL=0x1.
  - Required: timer_irq rises 6 edges after the CTRL write; CNT continues to 6, 7, ...
  - Stimulus: write CTRL=0x5.
  - Required: irq clears.
- Timer auto-reload and set-wins:
  - Stimulus: CMP=3, CTRL=0x3.
  - Required: CNT sequence is 0,1,2,3,0,1...
  - Stimulus: a W1C write on an edge where CNT==3.
  - Required: ST stays 1.
- Scanner with SCAN_DIV=4 and SEG=0x87654321:
  - Required: seg_an steps FE, FD, FB, ... 7F, FE every 4 cycles.
  - Required: seg_hex steps 1, 2, ... 8.
- Unmapped accesses:
  - Stimulus: load 0x7F18 or 0x0001_0000.
  - Required: returns 0.
  - Stimulus: store to the same addresses.
  - Required: no register or dm_we change.
